// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder slice plus a carry flop adds two
// WIDTH-bit operands LSB-first, one bit per clock, then pulses done with the sum.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ps;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_cn;
  logic [WIDTH-1:0] w_ps_next;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

  assign w_s       = fa_sum(r_a[0], r_b[0], r_c);
  assign w_cn      = fa_carry(r_a[0], r_b[0], r_c);
  assign w_ps_next = {w_s, r_ps[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ps    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_ps    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_ps  <= w_ps_next;
          r_c   <= w_cn;
          r_cnt <= r_cnt + CW'(1);
          // Exit decoded on the last bit so the counter never needs to wrap.
          if (r_cnt == LAST) begin
            r_sum   <= w_ps_next;
            r_cout  <= w_cn;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder at WIDTH=8 and WIDTH=16,
// compared against plain-arithmetic addition.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cout8, busy8, done8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cout16, busy16, done16;

  int checks = 0;
  int passes = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .sum(sum8), .c_out(cout8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16),
    .sum(sum16), .c_out(cout16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation started from IDLE; checks every cycle until back in IDLE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [8:0] ref_v;
    ref_v = {1'b0, a} + {1'b0, b};
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    for (int i = 0; i < 7; i++) begin
      check({tag, " busy"}, busy8, 1'b1);
      check({tag, " done_early"}, done8, 1'b0);
      tick();
    end
    check({tag, " busy_last"}, busy8, 1'b1);
    tick();
    check({tag, " done"}, done8, 1'b1);
    check({tag, " busy_fall"}, busy8, 1'b0);
    check({tag, " sum"}, sum8, ref_v[7:0]);
    check({tag, " c_out"}, cout8, ref_v[8]);
    tick();
    check({tag, " done_fall"}, done8, 1'b0);
    check({tag, " sum_hold"}, sum8, ref_v[7:0]);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int gap_bad;
    logic [16:0] ref16;
    logic [15:0] ra, rb;

    // Reset state
    repeat (3) tick();
    check("rst sum8", sum8, 8'h00);
    check("rst cout8", cout8, 1'b0);
    check("rst busy8", busy8, 1'b0);
    check("rst done8", done8, 1'b0);
    check("rst sum16", sum16, 16'h0000);
    check("rst busy16", busy16, 1'b0);
    rst_n = 1'b1;
    tick();

    // Directed operands
    op8(8'h3C, 8'h0F, "3C+0F");
    op8(8'hFF, 8'h01, "FF+01");
    op8(8'hFF, 8'hFF, "FF+FF");
    op8(8'h00, 8'h00, "00+00");

    // Second start during RUN must be ignored and not queued
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1; end
      else start8 = 1'b0;
      tick();
      if (done8) begin
        pulses++;
        check("ignore done_edge", i, 8);
        check("ignore sum", sum8, 8'h46);
        check("ignore c_out", cout8, 1'b0);
      end
    end
    start8 = 1'b0;
    check("ignore pulses", pulses, 1);

    // Continuous start: one completion every WIDTH+2 cycles
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    pulses = 0; last_pulse = -1; gap_bad = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      check("hold busy_done_excl", busy8 & done8, 1'b0);
      if (done8) begin
        if (last_pulse >= 0) check("hold period", i - last_pulse, 10);
        last_pulse = i;
        pulses++;
        check("hold sum", sum8, 8'h00);
        check("hold c_out", cout8, 1'b1);
      end else if (last_pulse >= 0) begin
        check("hold sum_stable", {cout8, sum8}, 9'h100);
      end
    end
    check("hold pulses", pulses >= 4, 1'b1);
    start8 = 1'b0;
    repeat (12) tick();

    // Reset mid-RUN discards the operation
    op8(8'h10, 8'h20, "10+20");
    a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    check("pre_rst busy", busy8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async sum", sum8, 8'h00);
    check("async c_out", cout8, 1'b0);
    check("async busy", busy8, 1'b0);
    check("async done", done8, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst no_done", done8, 1'b0);
    end
    op8(8'h01, 8'h02, "01+02");

    // Randomized 16-bit operations against A+B
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n == 0) begin ra = 16'hFFFF; rb = 16'h0001; end
      if (n == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; end
      ref16 = {1'b0, ra} + {1'b0, rb};
      a16 = ra; b16 = rb; start16 = 1'b1;
      tick();
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      repeat (15) tick();
      check("rnd no_early_done", done16, 1'b0);
      tick();
      check("rnd done", done16, 1'b1);
      check("rnd sum", sum16, ref16[15:0]);
      check("rnd c_out", cout16, ref16[16]);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder: the addition counterpart to the team's subtractor cells, for area-constrained datapaths. It accepts two WIDTH-bit operands on a start strobe and adds them LSB-first, one bit per clock, using a single full-adder slice and a carry flip-flop. It then presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits beside the subtractor blocks as the arithmetic unit for slow control paths.

## Interface

- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; sampled at the edge that accepts start.
- B  input  WIDTH  operand B; sampled at the edge that accepts start.
- sum  output  WIDTH  registered result (A+B) mod 2^WIDTH; held until the next completion.
- c_out  output  1  registered carry-out of the MSB; held with sum.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid and newly updated.

## Operation

- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 at an edge: load A and B into shift registers, clear the carry flop, clear the bit counter, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Compute s = a0 ^ b0 ^ c and c_next = (a0 & b0) | (c & (a0 ^ b0)), where a0/b0 are the operand shift-register LSBs and c is the carry flop.
  - Shift the operands right by one.
  - Shift s into the MSB of the partial-sum register.
  - Update the carry flop and increment the counter.
- After the WIDTH-th bit edge:
  - Copy the partial sum to sum and the final carry to c_out.
  - Go to DONE.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued. A and B changes outside the accepting edge have no effect.
- The counter is ceil(log2(WIDTH+1)) bits and never wraps: the RUN exit is decoded at count WIDTH-1.
- sum and c_out change only at the completion edge. They are stable in IDLE, RUN and DONE otherwise.
- Reset (rst_n=0, any time, including mid-RUN):
  - Immediately forces IDLE.
  - Drives sum=0, c_out=0, busy=0, done=0.
  - Clears the shift registers, carry and counter.
  - An in-flight operation is discarded with no done pulse.
  - Deassertion is assumed synchronous to clk by the system.

## Timing

- Reset values: sum=0, c_out=0, busy=0, done=0, state IDLE.
- For a start accepted at edge k:
  - busy=1 from after edge k until after edge k+WIDTH.
  - At edge k+WIDTH, sum and c_out update, busy falls, and done rises.
  - done falls at edge k+WIDTH+1, which returns to IDLE.
- Latency from the accepting edge to result valid: WIDTH cycles.
- Throughput: one operation per WIDTH+2 cycles. With start held high continuously, the next start is accepted at edge k+WIDTH+2.
- busy and done are never high together. All outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- Reset, then A=0x3C, B=0x0F, 1-cycle start (WIDTH=8):
  - busy is high for 8 cycles.
  - done pulses once at edge k+8, with sum=0x4B, c_out=0.
- A=0xFF, B=0x01 -> sum=0x00, c_out=1 (full carry ripple). A=0xFF, B=0xFF -> sum=0xFE, c_out=1. A=0x00, B=0x00 -> sum=0x00, c_out=0.
- Start an add of 0x12+0x34, then pulse start at cycle 3 of RUN with A=0xAA, B=0x55:
  - The second start is ignored.
  - Result is 0x46, c_out=0, with exactly one done pulse.
- Hold start=1 continuously with fixed A=0x80, B=0x80:
  - done pulses every 10 cycles.
  - Each result is sum=0x00, c_out=1.
  - sum is stable between pulses.
- Complete 0x10+0x20 (sum=0x30). Then start 0xF0+0x0F and assert rst_n=0 mid-RUN for 2 cycles:
  - Outputs go to 0 asynchronously, with no done pulse.
  - After release, a new 0x01+0x02 yields sum=0x03.
- Randomized check with WIDTH=16 against the reference sum A+B: 1000 operations, all sum and c_out values match.
